// File: rtl/decode_stage.sv
// decode_stage
//   Consumer end of the fetch-to-decoder interface. Raw instructions from
//   fetch are buffered in a small circular queue. Each queue head is decoded
//   into RV32I fields plus a sign-extended immediate, and the result is held
//   in a registered output with a valid/ready handshake toward execute. A
//   writeback branch (flush_i) discards everything in flight.
//
// Ports
//   clk, arstn                 clock, asynchronous active-low reset
//   fetch_valid_i              fetch offers an instruction
//   fetch_raw_instruction_i    raw instruction word
//   fetch_pc_i                 PC tag of the offered instruction
//   stall_o                    queue full; fetch must hold its offer
//   flush_i                    discard queue and output register
//   dec_ready_i                execute accepts the output this cycle
//   dec_valid_o                decoded output valid
//   dec_pc_o .. dec_funct7_o   PC and raw field slices of the instruction
//   dec_imm_o                  sign-extended immediate
//   dec_illegal_o              opcode not recognised
//   perf_decoded_o             (DECODE_PERF_CNT_EN only) output handshake count
//   perf_stall_o               (DECODE_PERF_CNT_EN only) stalled fetch cycles
//
// Build option
//   DECODE_PERF_CNT_EN         adds the two free-running performance counters

module decode_stage #(
  parameter int INS_SIZE    = 32,
  parameter int PC_WIDTH    = 32,
  parameter int QUEUE_DEPTH = 2
) (
  input  logic                clk,
  input  logic                arstn,
  input  logic                fetch_valid_i,
  input  logic [INS_SIZE-1:0] fetch_raw_instruction_i,
  input  logic [PC_WIDTH-1:0] fetch_pc_i,
  output logic                stall_o,
  input  logic                flush_i,
  input  logic                dec_ready_i,
  output logic                dec_valid_o,
  output logic [PC_WIDTH-1:0] dec_pc_o,
  output logic [6:0]          dec_opcode_o,
  output logic [4:0]          dec_rd_o,
  output logic [2:0]          dec_funct3_o,
  output logic [4:0]          dec_rs1_o,
  output logic [4:0]          dec_rs2_o,
  output logic [6:0]          dec_funct7_o,
  output logic [31:0]         dec_imm_o,
`ifdef DECODE_PERF_CNT_EN
  output logic [31:0]         perf_decoded_o,
  output logic [31:0]         perf_stall_o,
`endif
  output logic                dec_illegal_o
);

  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam int ENT_W = PC_WIDTH + INS_SIZE;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Queue storage
  logic [ENT_W-1:0] r_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Output register
  logic                r_valid;
  logic [PC_WIDTH-1:0] r_pc;
  logic [6:0]          r_opcode;
  logic [4:0]          r_rd;
  logic [2:0]          r_funct3;
  logic [4:0]          r_rs1;
  logic [4:0]          r_rs2;
  logic [6:0]          r_funct7;
  logic [31:0]         r_imm;
  logic                r_illegal;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [ENT_W-1:0]    w_head;
  logic [INS_SIZE-1:0] w_ins;
  logic [PC_WIDTH-1:0] w_head_pc;
  logic [31:0]         w_imm;
  logic                w_illegal;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign stall_o = w_full;

  // Fullness is judged on the pre-edge count, so a same-cycle pop never
  // makes room for the instruction being offered.
  assign w_push = fetch_valid_i & ~w_full & ~flush_i;
  assign w_pop  = ~w_empty & (~r_valid | dec_ready_i) & ~flush_i;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {fetch_pc_i, fetch_raw_instruction_i};
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign w_ins     = w_head[INS_SIZE-1:0];
  assign w_head_pc = w_head[ENT_W-1:INS_SIZE];

  always_comb begin
    w_imm     = '0;
    w_illegal = 1'b0;
    case (w_ins[6:0])
      OP_R:                       w_imm = '0;
      OP_IMM, OP_LOAD, OP_JALR:   w_imm = {{20{w_ins[31]}}, w_ins[31:20]};
      OP_STORE:                   w_imm = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
      OP_BRANCH:                  w_imm = {{19{w_ins[31]}}, w_ins[31], w_ins[7],
                                           w_ins[30:25], w_ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:           w_imm = {w_ins[31:12], 12'b0};
      OP_JAL:                     w_imm = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12],
                                           w_ins[20], w_ins[30:21], 1'b0};
      default:                    w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_rd      <= '0;
      r_funct3  <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_funct7  <= '0;
      r_imm     <= '0;
      r_illegal <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_pop) begin
      r_valid   <= 1'b1;
      r_pc      <= w_head_pc;
      r_opcode  <= w_ins[6:0];
      r_rd      <= w_ins[11:7];
      r_funct3  <= w_ins[14:12];
      r_rs1     <= w_ins[19:15];
      r_rs2     <= w_ins[24:20];
      r_funct7  <= w_ins[31:25];
      r_imm     <= w_imm;
      r_illegal <= w_illegal;
    end else if (dec_ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign dec_valid_o   = r_valid;
  assign dec_pc_o      = r_pc;
  assign dec_opcode_o  = r_opcode;
  assign dec_rd_o      = r_rd;
  assign dec_funct3_o  = r_funct3;
  assign dec_rs1_o     = r_rs1;
  assign dec_rs2_o     = r_rs2;
  assign dec_funct7_o  = r_funct7;
  assign dec_imm_o     = r_imm;
  assign dec_illegal_o = r_illegal;

`ifdef DECODE_PERF_CNT_EN
  // Counters survive flush; only reset clears them.
  logic [31:0] r_perf_decoded;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_perf_decoded <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (r_valid & dec_ready_i)    r_perf_decoded <= r_perf_decoded + 32'd1;
      if (fetch_valid_i & stall_o)  r_perf_stall   <= r_perf_stall + 32'd1;
    end
  end

  assign perf_decoded_o = r_perf_decoded;
  assign perf_stall_o   = r_perf_stall;
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        arstn;
  logic        fetch_valid_i;
  logic [31:0] fetch_raw_instruction_i;
  logic [31:0] fetch_pc_i;
  logic        stall_o;
  logic        flush_i;
  logic        dec_ready_i;
  logic        dec_valid_o;
  logic [31:0] dec_pc_o;
  logic [6:0]  dec_opcode_o;
  logic [4:0]  dec_rd_o;
  logic [2:0]  dec_funct3_o;
  logic [4:0]  dec_rs1_o;
  logic [4:0]  dec_rs2_o;
  logic [6:0]  dec_funct7_o;
  logic [31:0] dec_imm_o;
  logic        dec_illegal_o;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_decoded_o;
  logic [31:0] perf_stall_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  decode_stage dut (
    .clk                     (clk),
    .arstn                   (arstn),
    .fetch_valid_i           (fetch_valid_i),
    .fetch_raw_instruction_i (fetch_raw_instruction_i),
    .fetch_pc_i              (fetch_pc_i),
    .stall_o                 (stall_o),
    .flush_i                 (flush_i),
    .dec_ready_i             (dec_ready_i),
    .dec_valid_o             (dec_valid_o),
    .dec_pc_o                (dec_pc_o),
    .dec_opcode_o            (dec_opcode_o),
    .dec_rd_o                (dec_rd_o),
    .dec_funct3_o            (dec_funct3_o),
    .dec_rs1_o               (dec_rs1_o),
    .dec_rs2_o               (dec_rs2_o),
    .dec_funct7_o            (dec_funct7_o),
    .dec_imm_o               (dec_imm_o),
`ifdef DECODE_PERF_CNT_EN
    .perf_decoded_o          (perf_decoded_o),
    .perf_stall_o            (perf_stall_o),
`endif
    .dec_illegal_o           (dec_illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1ns so inputs change and outputs are sampled
  // away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    fetch_valid_i           = v;
    fetch_raw_instruction_i = ins;
    fetch_pc_i              = pc;
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    flush_i     = 1'b0;
    dec_ready_i = 1'b0;
    step();
    step();
    arstn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", dec_valid_o); end
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b exp 0", stall_o); end
    n_checks++; if ({dec_pc_o, dec_opcode_o, dec_rd_o, dec_funct3_o, dec_rs1_o, dec_rs2_o, dec_funct7_o, dec_imm_o, dec_illegal_o} !== '0)
      begin n_fail++; $display("FAIL reset_fields: pc %h op %h imm %h not all zero", dec_pc_o, dec_opcode_o, dec_imm_o); end
  endtask

  task automatic test_single();
    dec_ready_i = 1'b1;
    offer(1'b1, 32'h00500093, 32'h0);
    step();
    offer(1'b0, 32'h0, 32'h0);
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_lat1: valid got %b exp 0", dec_valid_o); end
    step();
    n_checks++; if (dec_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b exp 1", dec_valid_o); end
    n_checks++; if (dec_opcode_o !== 7'h13) begin n_fail++; $display("FAIL single_opcode: got %h exp 13", dec_opcode_o); end
    n_checks++; if (dec_rd_o !== 5'd1) begin n_fail++; $display("FAIL single_rd: got %0d exp 1", dec_rd_o); end
    n_checks++; if (dec_rs1_o !== 5'd0) begin n_fail++; $display("FAIL single_rs1: got %0d exp 0", dec_rs1_o); end
    n_checks++; if (dec_imm_o !== 32'h5) begin n_fail++; $display("FAIL single_imm: got %h exp 00000005", dec_imm_o); end
    n_checks++; if (dec_illegal_o !== 1'b0) begin n_fail++; $display("FAIL single_illegal: got %b exp 0", dec_illegal_o); end
    n_checks++; if (dec_pc_o !== 32'h0) begin n_fail++; $display("FAIL single_pc: got %h exp 0", dec_pc_o); end
    step();
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_drain: valid got %b exp 0", dec_valid_o); end
  endtask

  // B: 0xFE000EE3 -> imm bits {1,1,111111,1110,0} = -4 ; S: 0x00112423 -> imm 8
  task automatic test_back_to_back();
    dec_ready_i = 1'b1;
    offer(1'b1, 32'hFE000EE3, 32'h4);
    step();
    offer(1'b1, 32'h00112423, 32'h8);
    step();
    offer(1'b0, 32'h0, 32'h0);
    n_checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h4) begin n_fail++; $display("FAIL b2b_b_valid: valid %b pc %h exp 1 00000004", dec_valid_o, dec_pc_o); end
    n_checks++; if (dec_imm_o !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL b2b_b_imm: got %h exp fffffffc", dec_imm_o); end
    n_checks++; if (dec_opcode_o !== 7'h63) begin n_fail++; $display("FAIL b2b_b_opcode: got %h exp 63", dec_opcode_o); end
    step();
    n_checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h8) begin n_fail++; $display("FAIL b2b_s_valid: valid %b pc %h exp 1 00000008", dec_valid_o, dec_pc_o); end
    n_checks++; if (dec_imm_o !== 32'h8) begin n_fail++; $display("FAIL b2b_s_imm: got %h exp 00000008", dec_imm_o); end
    n_checks++; if (dec_rs2_o !== 5'd1 || dec_rs1_o !== 5'd2 || dec_funct3_o !== 3'd2)
      begin n_fail++; $display("FAIL b2b_s_regs: rs2 %0d rs1 %0d f3 %0d exp 1 2 2", dec_rs2_o, dec_rs1_o, dec_funct3_o); end
    step();
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: valid got %b exp 0", dec_valid_o); end
  endtask

  // U and J immediates streamed back to back
  task automatic test_u_j();
    dec_ready_i = 1'b1;
    offer(1'b1, 32'h12345037, 32'h20);
    step();
    offer(1'b1, 32'h008000EF, 32'h24);
    step();
    offer(1'b0, 32'h0, 32'h0);
    n_checks++; if (dec_imm_o !== 32'h12345000 || dec_pc_o !== 32'h20) begin n_fail++; $display("FAIL uj_u_imm: imm %h pc %h exp 12345000 00000020", dec_imm_o, dec_pc_o); end
    step();
    n_checks++; if (dec_imm_o !== 32'h8 || dec_rd_o !== 5'd1 || dec_pc_o !== 32'h24) begin n_fail++; $display("FAIL uj_j_imm: imm %h rd %0d pc %h exp 00000008 1 00000024", dec_imm_o, dec_rd_o, dec_pc_o); end
    step();
  endtask

  task automatic test_backpressure();
    dec_ready_i = 1'b0;
    offer(1'b1, 32'h00100093, 32'h10);   // A
    step();
    n_checks++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL bp_stall_a: got %b exp 0", stall_o); end
    offer(1'b1, 32'h00200113, 32'h14);   // B
    step();
    n_checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h10 || stall_o !== 1'b0)
      begin n_fail++; $display("FAIL bp_after_b: valid %b pc %h stall %b exp 1 00000010 0", dec_valid_o, dec_pc_o, stall_o); end
    offer(1'b1, 32'h00300193, 32'h18);   // C
    step();
    n_checks++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL bp_full: stall got %b exp 1", stall_o); end
    offer(1'b1, 32'h00400213, 32'h1C);   // D, held by fetch
    step();
    n_checks++; if (stall_o !== 1'b1 || dec_pc_o !== 32'h10 || dec_imm_o !== 32'h1)
      begin n_fail++; $display("FAIL bp_hold: stall %b pc %h imm %h exp 1 00000010 00000001", stall_o, dec_pc_o, dec_imm_o); end
    dec_ready_i = 1'b1;
    step();                               // D refused (pre-edge full), B loaded
    n_checks++; if (dec_pc_o !== 32'h14 || dec_imm_o !== 32'h2) begin n_fail++; $display("FAIL bp_out_b: pc %h imm %h exp 00000014 00000002", dec_pc_o, dec_imm_o); end
    step();                               // D enqueued, C loaded
    offer(1'b0, 32'h0, 32'h0);
    n_checks++; if (dec_pc_o !== 32'h18 || dec_imm_o !== 32'h3) begin n_fail++; $display("FAIL bp_out_c: pc %h imm %h exp 00000018 00000003", dec_pc_o, dec_imm_o); end
    step();
    n_checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h1C || dec_imm_o !== 32'h4)
      begin n_fail++; $display("FAIL bp_out_d: valid %b pc %h imm %h exp 1 0000001c 00000004", dec_valid_o, dec_pc_o, dec_imm_o); end
    step();
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_drain: valid got %b exp 0", dec_valid_o); end
  endtask

  task automatic test_flush();
    dec_ready_i = 1'b0;
    offer(1'b1, 32'h00100093, 32'h40);
    step();
    offer(1'b1, 32'h00200113, 32'h44);
    step();
    offer(1'b1, 32'h00300193, 32'h48);
    step();
    n_checks++; if (dec_valid_o !== 1'b1 || stall_o !== 1'b1) begin n_fail++; $display("FAIL flush_setup: valid %b stall %b exp 1 1", dec_valid_o, stall_o); end
    offer(1'b1, 32'h00500293, 32'h4C);   // dropped by the flush
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    n_checks++; if (dec_valid_o !== 1'b0 || stall_o !== 1'b0) begin n_fail++; $display("FAIL flush_clear: valid %b stall %b exp 0 0", dec_valid_o, stall_o); end
    dec_ready_i = 1'b1;
    step();
    step();
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: valid got %b exp 0", dec_valid_o); end
    offer(1'b1, 32'h00600313, 32'h50);
    step();
    offer(1'b0, 32'h0, 32'h0);
    step();
    n_checks++; if (dec_valid_o !== 1'b1 || dec_pc_o !== 32'h50 || dec_imm_o !== 32'h6 || dec_rd_o !== 5'd6)
      begin n_fail++; $display("FAIL flush_resume: valid %b pc %h imm %h rd %0d exp 1 00000050 00000006 6", dec_valid_o, dec_pc_o, dec_imm_o, dec_rd_o); end
    step();
  endtask

  task automatic test_illegal_and_reset();
    dec_ready_i = 1'b1;
    offer(1'b1, 32'hFFFFFFFF, 32'h60);
    step();
    offer(1'b1, 32'h00700393, 32'h64);
    step();
    n_checks++; if (dec_valid_o !== 1'b1 || dec_illegal_o !== 1'b1 || dec_imm_o !== 32'h0 || dec_opcode_o !== 7'h7F)
      begin n_fail++; $display("FAIL illegal: valid %b ill %b imm %h op %h exp 1 1 00000000 7f", dec_valid_o, dec_illegal_o, dec_imm_o, dec_opcode_o); end
    n_checks++; if (dec_funct7_o !== 7'h7F || dec_rs2_o !== 5'h1F) begin n_fail++; $display("FAIL illegal_fields: f7 %h rs2 %h exp 7f 1f", dec_funct7_o, dec_rs2_o); end
    #2;
    arstn = 1'b0;
    #1;
    n_checks++; if ({dec_valid_o, stall_o, dec_pc_o, dec_opcode_o, dec_rd_o, dec_funct3_o, dec_rs1_o, dec_rs2_o, dec_funct7_o, dec_imm_o, dec_illegal_o} !== '0)
      begin n_fail++; $display("FAIL async_reset: valid %b pc %h op %h imm %h ill %b exp all 0", dec_valid_o, dec_pc_o, dec_opcode_o, dec_imm_o, dec_illegal_o); end
    offer(1'b0, 32'h0, 32'h0);
    step();
    arstn = 1'b1;
    step();
    n_checks++; if (dec_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_lost: valid got %b exp 0", dec_valid_o); end
  endtask

`ifdef DECODE_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    offer(1'b1, 32'h00100093, 32'h0); step();
    offer(1'b1, 32'h00200113, 32'h4); step();
    offer(1'b1, 32'h00300193, 32'h8); step();
    offer(1'b1, 32'h00400213, 32'hC);
    step(); step(); step();              // three stalled cycles
    offer(1'b0, 32'h0, 32'h0);
    dec_ready_i = 1'b1;
    step(); step(); step();              // three handshakes
    offer(1'b1, 32'h00500293, 32'h10); step();
    offer(1'b1, 32'h00600313, 32'h14); step();
    offer(1'b0, 32'h0, 32'h0);
    step(); step();                      // two more handshakes
    n_checks++; if (perf_decoded_o !== 32'd5) begin n_fail++; $display("FAIL perf_decoded: got %0d exp 5", perf_decoded_o); end
    n_checks++; if (perf_stall_o !== 32'd3) begin n_fail++; $display("FAIL perf_stall: got %0d exp 3", perf_stall_o); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_u_j();
    test_backpressure();
    test_flush();
    test_illegal_and_reset();
`ifdef DECODE_PERF_CNT_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
